divisor_seq: RTL and testbench
==============================

// Module: divisor_seq
// PURPOSE
//  Sequential restoring divider, inverse of the shift-add multiplier: divides a
//  2W-bit dividend by a W-bit divisor, yielding W-bit quotient and remainder.
//  One quotient bit per clock. Uses the same St/done1 start/complete handshake
//  as the multiplier. Datapath helper for MIPS DIV/DIVU.
// PARAMETERS
//  W    16   divisor/quotient/remainder width; dividend is 2W bits
// PORTS
//  clk     in   1    clock, rising edge
//  rst_n   in   1    asynchronous reset, active-low
//  St      in   1    start request, level-sampled in IDLE only
//  dvdo    in   2W   dividend, sampled with St
//  dsor    in   W    divisor, sampled with St
//  done1   out  1    one-cycle pulse: quoc/resto/ovf valid
//  quoc    out  W    quotient (registered)
//  resto   out  W    remainder (registered)
//  ovf     out  1    divide-by-zero or quotient overflow (registered)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, done1=0, quoc=0, resto=0, ovf=0, counter=0.
//  - States: IDLE -> CHECK -> CALC (W cycles) -> DONE -> IDLE.
//  - IDLE: at edge E0 with St=1, latch dvdo/dsor into internal regs; go to CHECK.
//    St=0: stay. Operand changes after E0 are ignored.
//  - CHECK (E1): if dsor==0 or dvdo[2W-1:W] >= dsor, then ovf=1, quoc=all ones,
//    resto=0, go to DONE. Otherwise clear ovf, load partial rem = dvdo[2W-1:W],
//    low reg = dvdo[W-1:0], counter=0, go to CALC.
//  - CALC, each edge: shift {rem,low} left 1 into a (W+1)-bit trial; if trial >= dsor,
//    rem = trial-dsor, shift in 1, else rem = trial, shift in 0. counter++.
//    After W iterations go to DONE. Keep the carry-out bit: no truncation to W bits.
//  - DONE: done1=1 for exactly one cycle. quoc/resto update on the edge that enters DONE.
//    Next edge returns to IDLE.
//  - Latency: normal op: done1 high in the cycle after edge E0+W+2.
//    Overflow: done1 high after edge E0+2.
//  - quoc/resto/ovf hold their value until the next op enters DONE or reset.
//  - St while busy (CHECK/CALC/DONE): ignored; no queueing.
//  - St held high: back-to-back ops; a new op starts in IDLE one cycle after done1.
//  - Reset mid-operation: immediate abort to reset values; no done1 pulse.
//  - Boundary: dvdo=0 gives quoc=0, resto=0. dsor=1 with dvdo<2^W gives quoc=dvdo[W-1:0].
// CONFIGURATION
//  DIV_SIGNED_EN defined: operands are two's complement.
//   - CHECK takes the absolute values and records the quotient and dividend signs.
//   - After CALC, an extra FIX cycle negates the quotient if the signs differ and
//     gives the remainder the dividend's sign. Quotient truncates toward zero.
//   - Signed latency is one cycle longer.
//   - ovf=1 if dsor==0 or the true quotient is outside [-2^(W-1), 2^(W-1)-1].
//  DIV_SIGNED_EN undefined: unsigned only, no FIX state; logic above is absent.
// TESTING
//  1. dvdo=32'hFFFE0001, dsor=16'hFFFF, St=1 -> done1 pulse after W+2 edges;
//     quoc=16'hFFFF, resto=16'h0000, ovf=0.
//  2. dvdo=32'd100, dsor=16'd7 -> quoc=16'd14, resto=16'd2, ovf=0. Then
//     dvdo=32'h0000FFFF, dsor=16'h0100 -> quoc=16'h00FF, resto=16'h00FF.
//  3. dsor=0 (any dvdo) -> ovf=1, quoc=16'hFFFF, resto=0, done1 after 2 edges.
//     dvdo=32'h00010000, dsor=1 -> ovf=1.
//  4. Pull rst_n low 5 cycles into CALC -> outputs 0 immediately, no done1, state IDLE.
//     Reissuing the op from test 2 then completes correctly.
//  5. St held high with changing operands -> consecutive done1 pulses exactly W+4
//     cycles apart; each result matches the operands sampled at its start edge.
//  6. (DIV_SIGNED_EN) dvdo=-100, dsor=7 -> quoc=-14 (16'hFFF2), resto=-2 (16'hFFFE).
//     dvdo=32'h00008000, dsor=1 -> ovf=1.

Source files
------------

// File: rtl/divisor_seq.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (adds a sign-fix cycle).
module divisor_seq #(
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           St,
    input  logic [2*W-1:0] dvdo,
    input  logic [W-1:0]   dsor,
    output logic           done1,
    output logic [W-1:0]   quoc,
    output logic [W-1:0]   resto,
    output logic           ovf
);

    localparam int unsigned DW = 2 * W;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [W-1:0]  dsr_q, dsr_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  low_q, low_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quoc_q, quoc_d;
    logic [W-1:0]  resto_q, resto_d;
    logic          ovf_q, ovf_d;
    logic          done1_q, done1_d;

    // One restoring step: the trial keeps the shifted-out bit so it never truncates.
    logic [W:0]    trial;
    logic          fits;
    logic [W-1:0]  rem_nx;
    logic [W-1:0]  low_nx;
    logic          last;

    assign trial  = {rem_q, low_q[W-1]};
    assign fits   = trial >= {1'b0, dsr_q};
    assign rem_nx = fits ? W'(trial - {1'b0, dsr_q}) : trial[W-1:0];
    assign low_nx = {low_q[W-2:0], fits};
    assign last   = cnt_q == CW'(W - 1);

    logic [DW-1:0] chk_dvd;
    logic [W-1:0]  chk_dsr;

`ifdef DIV_SIGNED_EN
    localparam logic [W-1:0] MIN_MAG = W'(1) << (W - 1);

    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          fix_ovf;
    logic [W-1:0]  q_neg;
    logic [W-1:0]  r_neg;

    // Divide magnitudes; signs are restored in the FIX cycle.
    assign chk_dvd = dvd_q[DW-1] ? DW'(~dvd_q + DW'(1)) : dvd_q;
    assign chk_dsr = dsr_q[W-1]  ? W'(~dsr_q + W'(1))   : dsr_q;
    assign fix_ovf = qneg_q ? (low_q > MIN_MAG) : low_q[W-1];
    assign q_neg   = W'(~low_q + W'(1));
    assign r_neg   = W'(~rem_q + W'(1));
`else
    assign chk_dvd = dvd_q;
    assign chk_dsr = dsr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            low_q   <= '0;
            cnt_q   <= '0;
            quoc_q  <= '0;
            resto_q <= '0;
            ovf_q   <= 1'b0;
            done1_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            low_q   <= low_d;
            cnt_q   <= cnt_d;
            quoc_q  <= quoc_d;
            resto_q <= resto_d;
            ovf_q   <= ovf_d;
            done1_q <= done1_d;
`ifdef DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        low_d   = low_q;
        cnt_d   = cnt_q;
        quoc_d  = quoc_q;
        resto_d = resto_q;
        ovf_d   = ovf_q;
        done1_d = state_q == S_DONE;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            // The done1 cycle itself is not a start slot, so back-to-back ops space out by one.
            S_IDLE: begin
                if (St && !done1_q) begin
                    dvd_d   = dvdo;
                    dsr_d   = dsor;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (chk_dsr == '0 || chk_dvd[DW-1:W] >= chk_dsr) begin
                    ovf_d   = 1'b1;
                    quoc_d  = '1;
                    resto_d = '0;
                    state_d = S_DONE;
                end else begin
                    ovf_d   = 1'b0;
                    rem_d   = chk_dvd[DW-1:W];
                    low_d   = chk_dvd[W-1:0];
                    dsr_d   = chk_dsr;
                    cnt_d   = '0;
                    state_d = S_CALC;
`ifdef DIV_SIGNED_EN
                    qneg_d  = dvd_q[DW-1] ^ dsr_q[W-1];
                    rneg_d  = dvd_q[DW-1];
`endif
                end
            end
            S_CALC: begin
                rem_d = rem_nx;
                low_d = low_nx;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
`ifdef DIV_SIGNED_EN
                    state_d = S_FIX;
`else
                    quoc_d  = low_nx;
                    resto_d = rem_nx;
                    state_d = S_DONE;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            S_FIX: begin
                if (fix_ovf) begin
                    ovf_d   = 1'b1;
                    quoc_d  = '1;
                    resto_d = '0;
                end else begin
                    ovf_d   = 1'b0;
                    quoc_d  = qneg_q ? q_neg : low_q;
                    resto_d = rneg_q ? r_neg : rem_q;
                end
                state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign done1 = done1_q;
    assign quoc  = quoc_q;
    assign resto = resto_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_divisor_seq.sv
// Scoreboard bench for divisor_seq: directed and random ops against an arithmetic reference.
module tb_divisor_seq;

    localparam int unsigned W  = 16;
    localparam int unsigned DW = 2 * W;
`ifdef DIV_SIGNED_EN
    localparam int LAT_N = W + 3;
`else
    localparam int LAT_N = W + 2;
`endif
    localparam int LAT_OVF = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          St    = 1'b0;
    logic [DW-1:0] dvdo  = '0;
    logic [W-1:0]  dsor  = '0;
    logic          done1;
    logic [W-1:0]  quoc;
    logic [W-1:0]  resto;
    logic          ovf;

    divisor_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .St    (St),
        .dvdo  (dvdo),
        .dsor  (dsor),
        .done1 (done1),
        .quoc  (quoc),
        .resto (resto),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t scb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    // Reference: plain integer division; e0 is the posedge that samples St.
    function automatic exp_t ref_div(input logic [DW-1:0] a, input logic [W-1:0] b, input int e0);
        exp_t   e;
        longint q;
        longint r;
        longint qm;
`ifdef DIV_SIGNED_EN
        longint sa;
        longint sb;
        sa = $signed(a);
        sb = $signed(b);
        e.ovf = 1'b1; e.q = '1; e.r = '0; e.cyc = e0 + LAT_OVF;
        if (sb != 0) begin
            q  = sa / sb;
            r  = sa % sb;
            qm = (q < 0) ? -q : q;
            if (qm < (longint'(1) << W)) begin
                e.cyc = e0 + LAT_N;
                if (q <= (longint'(1) << (W - 1)) - 1 && q >= -(longint'(1) << (W - 1))) begin
                    e.ovf = 1'b0;
                    e.q   = W'(q);
                    e.r   = W'(r);
                end
            end
        end
`else
        longint ua;
        longint ub;
        ua = longint'(a);
        ub = longint'(b);
        e.ovf = 1'b1; e.q = '1; e.r = '0; e.cyc = e0 + LAT_OVF;
        if (ub != 0) begin
            q  = ua / ub;
            r  = ua % ub;
            qm = q;
            if (qm < (longint'(1) << W)) begin
                e.ovf = 1'b0;
                e.q   = W'(q);
                e.r   = W'(r);
                e.cyc = e0 + LAT_N;
            end
        end
`endif
        return e;
    endfunction

    // Monitor: every done1 must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done1) begin
                if (scb.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_done1: got done1=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = scb.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("quoc", 64'(quoc), 64'(e.q));
                    chk("resto", 64'(resto), 64'(e.r));
                    chk("ovf", 64'(ovf), 64'(e.ovf));
                end
            end else if (scb.size() != 0 && cyc > scb[0].cyc) begin
                n_chk++;
                $display("FAIL missing_done1: got none expected at cycle %0d (now %0d)", scb[0].cyc, cyc);
                void'(scb.pop_front());
            end
        end
    end

    // One isolated op; operands are scrambled right after the sampling edge.
    task automatic issue(input logic [DW-1:0] a, input logic [W-1:0] b);
        dvdo = a;
        dsor = b;
        St   = 1'b1;
        scb.push_back(ref_div(a, b, cyc + 1));
        @(negedge clk);
        St   = 1'b0;
        dvdo = {$urandom, $urandom};
        dsor = W'($urandom);
        repeat (W + 6) @(negedge clk);
    endtask

    task automatic rand_ops(output logic [DW-1:0] a, output logic [W-1:0] b);
        int unsigned mode;
        mode = $urandom_range(0, 3);
        b    = W'($urandom);
        a    = {$urandom, $urandom};
        if (mode == 0) b = '0;
        else if (mode >= 2 && b != '0) a[DW-1:W] = W'($urandom % b);
    endtask

    initial begin
        logic [DW-1:0] a;
        logic [W-1:0]  b;
        int            ns;
        int            ops;
        exp_t          e;

        repeat (3) @(negedge clk);
        chk("rst_done1", 64'(done1), 64'(0));
        chk("rst_quoc", 64'(quoc), 64'(0));
        chk("rst_resto", 64'(resto), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'hFFFE0001, 16'hFFFF);
        issue(32'd100, 16'd7);
        issue(32'h0000FFFF, 16'h0100);
        issue(32'h12345678, 16'h0000);
        issue(32'h00010000, 16'h0001);
        issue(32'h00000000, 16'h0005);
        issue(32'h0000ABCD, 16'h0001);
        issue(32'h7FFFFFFF, 16'h8000);

        // Abort mid-CALC: outputs clear at once and no done1 may follow.
        dvdo = 32'd100;
        dsor = 16'd7;
        St   = 1'b1;
        @(negedge clk);
        St = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_done1", 64'(done1), 64'(0));
        chk("abort_quoc", 64'(quoc), 64'(0));
        chk("abort_resto", 64'(resto), 64'(0));
        chk("abort_ovf", 64'(ovf), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 6) @(negedge clk);
        issue(32'd100, 16'd7);

`ifdef DIV_SIGNED_EN
        issue(32'hFFFFFF9C, 16'd7);
        issue(32'h00008000, 16'd1);
        issue(32'hFFFF8000, 16'd1);
        issue(32'd100, 16'hFFF9);
`endif

        for (int i = 0; i < 6; i++) begin
            rand_ops(a, b);
            issue(a, b);
        end

        // St held high with operands changing every cycle.
        ns  = cyc + 1;
        ops = 0;
        St  = 1'b1;
        while (ops < 12) begin
            rand_ops(a, b);
            dvdo = a;
            dsor = b;
            if (cyc + 1 == ns) begin
                e = ref_div(a, b, ns);
                scb.push_back(e);
                ns = e.cyc + 2;
                ops++;
            end
            @(negedge clk);
        end
        St = 1'b0;
        repeat (W + 8) @(negedge clk);

        chk("scoreboard_empty", 64'(scb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
